// File: rtl/mac_seq_if.sv
// mac_seq_if: job, operand, result and mac_block bundle; master is the environment side, slave is mac_seq
interface mac_seq_if #(
  parameter int MIN_W = 8,
  parameter int ACC_W = 32,
  parameter int CONF_W = 3,
  parameter int LEN_W = 8
);
  logic job_valid;
  logic job_ready;
  logic [LEN_W-1:0] job_len;
  logic [1:0] job_mode;
  logic job_acc;
  logic [ACC_W-1:0] job_init;
  logic op_valid;
  logic op_ready;
  logic [MIN_W-1:0] op_a;
  logic [MIN_W-1:0] op_b;
  logic [MIN_W-1:0] op_dual;
  logic [MIN_W-1:0] op_q1;
  logic [MIN_W-1:0] op_q2;
  logic mac_en;
  logic [MIN_W-1:0] mac_a;
  logic [MIN_W-1:0] mac_b;
  logic [MIN_W-1:0] mac_dual;
  logic [MIN_W-1:0] mac_q1;
  logic [MIN_W-1:0] mac_q2;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [ACC_W-1:0] mac_c;
  logic res_valid;
  logic res_ready;
  logic [ACC_W-1:0] res_data;
  logic busy;
  modport master (
    output job_valid, job_len, job_mode, job_acc, job_init,
    output op_valid, op_a, op_b, op_dual, op_q1, op_q2,
    output mac_c, res_ready,
    input job_ready, op_ready, mac_en, mac_a, mac_b, mac_dual, mac_q1, mac_q2, mac_cfg,
    input res_valid, res_data, busy
  );
  modport slave (
    input job_valid, job_len, job_mode, job_acc, job_init,
    input op_valid, op_a, op_b, op_dual, op_q1, op_q2,
    input mac_c, res_ready,
    output job_ready, op_ready, mac_en, mac_a, mac_b, mac_dual, mac_q1, mac_q2, mac_cfg,
    output res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_seq.sv
// mac_seq: job sequencer upstream of mac_block (define MAC_SEQ_PERF_EN to add perf_cycles/perf_stall counters)
module mac_seq #(
  parameter int MIN_W = 8,
  parameter int ACC_W = 32,
  parameter int CONF_W = 3,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic rst,
  mac_seq_if.slave bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUT} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic acc_q, acc_d;
  logic [ACC_W+CONF_W-1:0] cfg_q, cfg_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [MIN_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d, q1_q, q1_d, q2_q, q2_d;
  logic fire;
  assign fire = state_q == RUN && bus.op_valid;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    acc_d = acc_q;
    cfg_d = cfg_q;
    res_d = res_q;
    a_d = fire ? bus.op_a : a_q;
    b_d = fire ? bus.op_b : b_q;
    d_d = fire ? bus.op_dual : d_q;
    q1_d = fire ? bus.op_q1 : q1_q;
    q2_d = fire ? bus.op_q2 : q2_q;
    case (state_q)
      IDLE: if (bus.job_valid) begin
        rem_d = bus.job_len;
        acc_d = bus.job_acc;
        cfg_d = '0;
        cfg_d[ACC_W+CONF_W-1:CONF_W] = bus.job_init;
        cfg_d[CONF_W-1] = bus.job_acc;
        cfg_d[1:0] = bus.job_mode == 2'b11 ? 2'b00 : bus.job_mode;
        state_d = bus.job_len == '0 ? OUT : LOAD;
        res_d = bus.job_len != '0 ? res_q : bus.job_acc ? bus.job_init : '0;
      end
      LOAD: state_d = RUN;
      RUN: if (fire) begin
        rem_d = rem_q - LEN_W'(1);
        state_d = (!acc_q || rem_q == LEN_W'(1)) ? DRAIN : RUN;
      end
      DRAIN: begin
        res_d = bus.mac_c;
        state_d = OUT;
      end
      OUT: if (bus.res_ready) state_d = rem_q != '0 ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      acc_q <= 1'b0;
      cfg_q <= '0;
      res_q <= '0;
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      acc_q <= acc_d;
      cfg_q <= cfg_d;
      res_q <= res_d;
      a_q <= a_d;
      b_q <= b_d;
      d_q <= d_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end
  assign bus.job_ready = state_q == IDLE;
  assign bus.op_ready = state_q == RUN;
  assign bus.busy = state_q != IDLE;
  assign bus.res_valid = state_q == OUT;
  assign bus.res_data = res_q;
  assign bus.mac_cfg = cfg_q;
  assign bus.mac_en = fire;
  assign bus.mac_a = a_d;
  assign bus.mac_b = b_d;
  assign bus.mac_dual = d_d;
  assign bus.mac_q1 = q1_d;
  assign bus.mac_q2 = q2_d;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;
  always_comb begin
    cyc_d = cyc_q + {31'd0, state_q != IDLE};
    stall_d = stall_q + {31'd0, (state_q == RUN && !bus.op_valid) || (state_q == OUT && !bus.res_ready)};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      stall_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stall_q <= stall_d;
    end
  end
  assign perf_cycles = cyc_q;
  assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed self-checking bench for mac_seq with a behavioural single-mode mac_block model
module tb_mac_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  mac_seq_if bus ();
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif
  mac_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MAC_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  logic [31:0] c_q;
  logic busy_p;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
      busy_p <= 1'b0;
    end else begin
      busy_p <= bus.busy;
      if (bus.mac_en) c_q <= (bus.mac_cfg[2] ? c_q : 32'd0) + 32'(bus.mac_a) * 32'(bus.mac_b);
      else if (bus.busy && !busy_p) c_q <= bus.mac_cfg[34:3];
    end
  end
  assign bus.mac_c = c_q;
  task automatic drive_job(
    input logic [7:0] len, input logic [1:0] mode, input logic acc, input logic [31:0] init,
    input logic [31:0] av, input logic [31:0] bv, input int gap, input int hold, input int nexp,
    output int nres, output logic [31:0] r0, output logic [31:0] r1, output int en_cnt, output int en_bad,
    output int lat, output int opr_low, output int op_hs, output int out_bad, output logic [34:0] cfg
  );
    int beat, gcnt, rw, lat_cnt;
    logic hs_job, hs_op, hs_res, rv, counting, first;
    logic [31:0] rd;
    nres = 0; r0 = '0; r1 = '0; en_cnt = 0; en_bad = 0; lat = -1; opr_low = 0; op_hs = 0; out_bad = 0; cfg = '0;
    beat = 0; gcnt = 0; rw = 0; lat_cnt = 0; counting = 1'b0; first = 1'b1; rd = '0;
    bus.job_valid = 1'b1; bus.job_len = len; bus.job_mode = mode; bus.job_acc = acc; bus.job_init = init;
    bus.op_valid = len != 0; bus.op_a = av[7:0]; bus.op_b = bv[7:0];
    bus.res_ready = hold == 0;
    for (int cyc = 0; cyc < 300 && nres != nexp; cyc++) begin
      @(negedge clk);
      hs_job = bus.job_valid && bus.job_ready;
      hs_op = bus.op_valid && bus.op_ready;
      rv = bus.res_valid;
      hs_res = rv && bus.res_ready;
      if (counting) lat_cnt++;
      if (hs_job) begin counting = 1'b1; lat_cnt = 0; end
      if (bus.mac_en) en_cnt++;
      if (bus.mac_en !== hs_op) en_bad++;
      if (hs_op) op_hs++;
      if (beat > 0 && beat < int'(len) && !bus.op_ready) opr_low++;
      if (bus.busy) cfg = bus.mac_cfg;
      if (rv && lat < 0) lat = lat_cnt;
      if (rv) begin
        if (!first && bus.res_data !== rd) out_bad++;
        if (bus.job_ready || bus.op_ready) out_bad++;
        if (first) begin rd = bus.res_data; first = 1'b0; end
        if (hs_res) begin
          if (nres == 0) r0 = rd; else r1 = rd;
          nres++;
          first = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (hs_job) bus.job_valid = 1'b0;
      if (hs_op) begin
        beat++;
        if (beat >= int'(len)) bus.op_valid = 1'b0;
        else if (gap > 0) begin bus.op_valid = 1'b0; gcnt = gap; end
        else begin bus.op_a = av[8*beat +: 8]; bus.op_b = bv[8*beat +: 8]; end
      end else if (gcnt > 0) begin
        gcnt--;
        if (gcnt == 0) begin bus.op_valid = 1'b1; bus.op_a = av[8*beat +: 8]; bus.op_b = bv[8*beat +: 8]; end
      end
      if (hs_res) begin bus.res_ready = hold == 0; rw = 0; end
      else if (rv) begin rw++; if (rw >= hold) bus.res_ready = 1'b1; end
    end
    bus.op_valid = 1'b0;
    bus.job_valid = 1'b0;
    bus.res_ready = 1'b0;
  endtask
  int nres, en_cnt, en_bad, lat, opr_low, op_hs, out_bad;
  logic [31:0] r0, r1;
  logic [34:0] cfg;
  task automatic test_reset;
    #1;
    checks += 7;
    if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %0b want 1", bus.job_ready); end
    if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready got %0b want 0", bus.op_ready); end
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", bus.res_valid); end
    if (bus.res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got %0h want 0", bus.res_data); end
    if (bus.mac_en !== 1'b0) begin errors++; $display("FAIL reset_mac_en got %0b want 0", bus.mac_en); end
    if (bus.mac_cfg !== 35'd0) begin errors++; $display("FAIL reset_mac_cfg got %0h want 0", bus.mac_cfg); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_acc_single;
    drive_job(8'd4, 2'b00, 1'b1, 32'd10, 32'h04030201, 32'h02020202, 0, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 5;
    if (nres != 1) begin errors++; $display("FAIL acc_nres got %0d want 1", nres); end
    if (r0 !== 32'd30) begin errors++; $display("FAIL acc_result got %0d want 30", r0); end
    if (en_cnt != 4) begin errors++; $display("FAIL acc_en_pulses got %0d want 4", en_cnt); end
    if (lat != 7) begin errors++; $display("FAIL acc_latency got %0d want 7", lat); end
    if (cfg !== {32'd10, 1'b1, 2'b00}) begin errors++; $display("FAIL acc_cfg got %0h want %0h", cfg, {32'd10, 1'b1, 2'b00}); end
  endtask
  task automatic test_mult_only;
    drive_job(8'd2, 2'b00, 1'b0, 32'd0, 32'h00000503, 32'h00000707, 0, 0, 2,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 5;
    if (nres != 2) begin errors++; $display("FAIL mult_nres got %0d want 2", nres); end
    if (r0 !== 32'd21) begin errors++; $display("FAIL mult_r0 got %0d want 21", r0); end
    if (r1 !== 32'd35) begin errors++; $display("FAIL mult_r1 got %0d want 35", r1); end
    if (en_cnt != 2) begin errors++; $display("FAIL mult_en_pulses got %0d want 2", en_cnt); end
    if (opr_low != 2) begin errors++; $display("FAIL mult_op_ready_low got %0d want 2", opr_low); end
  endtask
  task automatic test_len_zero;
    drive_job(8'd0, 2'b00, 1'b1, 32'h55, 32'h0, 32'h0, 0, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 3;
    if (r0 !== 32'h55) begin errors++; $display("FAIL len0_acc_result got %0h want 55", r0); end
    if (op_hs != 0) begin errors++; $display("FAIL len0_acc_op_hs got %0d want 0", op_hs); end
    if (lat != 1) begin errors++; $display("FAIL len0_acc_latency got %0d want 1", lat); end
    drive_job(8'd0, 2'b00, 1'b0, 32'h55, 32'h0, 32'h0, 0, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 3;
    if (nres != 1) begin errors++; $display("FAIL len0_mul_nres got %0d want 1", nres); end
    if (r0 !== 32'h0) begin errors++; $display("FAIL len0_mul_result got %0h want 0", r0); end
    if (en_cnt != 0) begin errors++; $display("FAIL len0_mul_en got %0d want 0", en_cnt); end
  endtask
  task automatic test_gaps;
    drive_job(8'd3, 2'b00, 1'b1, 32'd10, 32'h00030201, 32'h00020202, 2, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 4;
    if (r0 !== 32'd22) begin errors++; $display("FAIL gap_result got %0d want 22", r0); end
    if (en_cnt != 3) begin errors++; $display("FAIL gap_en_pulses got %0d want 3", en_cnt); end
    if (en_bad != 0) begin errors++; $display("FAIL gap_en_vs_handshake got %0d want 0", en_bad); end
    if (op_hs != 3) begin errors++; $display("FAIL gap_op_hs got %0d want 3", op_hs); end
  endtask
  task automatic test_backpressure;
    drive_job(8'd2, 2'b00, 1'b1, 32'd1, 32'h00000504, 32'h00000303, 0, 5, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 3;
    if (r0 !== 32'd28) begin errors++; $display("FAIL bp_result got %0d want 28", r0); end
    if (nres != 1) begin errors++; $display("FAIL bp_nres got %0d want 1", nres); end
    if (out_bad != 0) begin errors++; $display("FAIL bp_out_stability got %0d want 0", out_bad); end
    @(negedge clk);
    checks += 2;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_retired_valid got %0b want 0", bus.res_valid); end
    if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_job_ready got %0b want 1", bus.job_ready); end
    @(posedge clk); #1;
  endtask
  task automatic test_cfg_mode;
    drive_job(8'd1, 2'b11, 1'b1, 32'h1234, 32'h00000003, 32'h00000004, 0, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 2;
    if (cfg !== 35'h91A4) begin errors++; $display("FAIL cfg_mode11 got %0h want 91a4", cfg); end
    if (r0 !== 32'h1240) begin errors++; $display("FAIL cfg_result got %0h want 1240", r0); end
  endtask
  task automatic test_reset_mid;
    int n;
    n = 0;
    bus.job_valid = 1'b1; bus.job_len = 8'd4; bus.job_mode = 2'b00; bus.job_acc = 1'b1; bus.job_init = 32'd0;
    bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd1; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      if (bus.mac_en) n++;
      @(posedge clk);
    end
    #1;
    checks += 2;
    if (n != 2) begin errors++; $display("FAIL rstmid_beats got %0d want 2", n); end
    if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_run got %0b want 1", bus.op_ready); end
    rst = 1'b0;
    #1;
    checks += 8;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
    if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL rstmid_job_ready got %0b want 1", bus.job_ready); end
    if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL rstmid_op_ready got %0b want 0", bus.op_ready); end
    if (bus.mac_en !== 1'b0) begin errors++; $display("FAIL rstmid_mac_en got %0b want 0", bus.mac_en); end
    if (bus.mac_a !== 8'd0) begin errors++; $display("FAIL rstmid_mac_a got %0h want 0", bus.mac_a); end
    if (bus.mac_cfg !== 35'd0) begin errors++; $display("FAIL rstmid_mac_cfg got %0h want 0", bus.mac_cfg); end
    if (bus.res_data !== 32'd0) begin errors++; $display("FAIL rstmid_res_data got %0h want 0", bus.res_data); end
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got %0b want 0", bus.res_valid); end
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    drive_job(8'd1, 2'b00, 1'b1, 32'd0, 32'h00000002, 32'h00000003, 0, 0, 1,
              nres, r0, r1, en_cnt, en_bad, lat, opr_low, op_hs, out_bad, cfg);
    checks += 2;
    if (nres != 1) begin errors++; $display("FAIL rstmid_after_nres got %0d want 1", nres); end
    if (r0 !== 32'd6) begin errors++; $display("FAIL rstmid_after_result got %0d want 6", r0); end
  endtask
  initial begin
    bus.job_valid = 1'b0; bus.job_len = '0; bus.job_mode = '0; bus.job_acc = 1'b0; bus.job_init = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_dual = '0; bus.op_q1 = '0; bus.op_q2 = '0;
    bus.res_ready = 1'b0;
    test_reset;
    test_acc_single;
    test_mult_only;
    test_len_zero;
    test_gaps;
    test_backpressure;
    test_cfg_mode;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Job sequencer that sits directly upstream of mac_block.
- Accepts a job descriptor and a valid/ready operand stream.
- Drives mac_block's en/A/B/dual_in/quad_in1/quad_in2/cfg.
- Captures mac_block's C output at the correct pipeline cycle and returns it on a valid/ready result port. This decouples the array from producer and consumer backpressure.

Parameters:
- MIN_W, 8, operand width (matches MAC_MIN_WIDTH)
- ACC_W, 32, accumulator/result width (matches MAC_ACC_WIDTH)
- CONF_W, 3, config field width (matches CONF_WIDTH)
- LEN_W, 8, job length counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accept (high only in IDLE)
- job_len  in  LEN_W  number of operand beats
- job_mode  in  2  00 single, 01 dual, 10 quad; 11 is treated as 00
- job_acc  in  1  1 = accumulate over all beats, 0 = one result per beat
- job_init  in  ACC_W  accumulator initial value
- op_valid / op_ready  in / out  1  operand handshake
- op_a, op_b, op_dual, op_q1, op_q2  in  MIN_W each  operand beat
- mac_en  out  1  to mac_block en
- mac_a, mac_b, mac_dual, mac_q1, mac_q2  out  MIN_W each  to mac_block A/B/dual_in/quad_in1/quad_in2
- mac_cfg  out  ACC_W+CONF_W  {init, acc, 0…, mode}; bit CONF_W-1 = acc, bits [1:0] = mode
- mac_c  in  ACC_W  from mac_block C
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  ACC_W  result
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counters 0, res_valid 0, res_data 0, mac_en 0, mac operand outputs 0, mac_cfg 0. Any in-flight job is dropped; no result is produced for it.
- States: IDLE, LOAD, RUN, DRAIN, OUT.
- IDLE:
  - job_ready=1.
  - On job_valid: latch descriptor, set remaining=job_len, go to LOAD.
  - If job_len==0: go straight to OUT with res_data = job_acc ? job_init : 0; no operand is consumed.
- LOAD (1 cycle):
  - mac_cfg driven from latched descriptor and held stable for the whole job; mac_en=0.
  - mac_block loads init_val into its accumulator on this cycle.
  - Go to RUN.
- RUN:
  - op_ready=1.
  - On op_valid&&op_ready: operands registered onto mac_* outputs with mac_en=1 in the same cycle; remaining decrements.
  - If job_acc=0, or the decrement brings remaining to 0: go to DRAIN.
  - Cycles with op_valid=0: mac_en=0, operands held.
- DRAIN (1 cycle):
  - mac_en=0; this cycle absorbs mac_block's one-cycle latency.
  - At the end of the cycle res_data<=mac_c, res_valid<=1; go to OUT.
- OUT:
  - res_valid=1; res_data stable until res_ready.
  - On res_ready: res_valid clears. If remaining!=0 (mult-only mode) go to RUN; otherwise go to IDLE.
- Throughput:
  - Accumulate mode: 1 beat/cycle, plus 3 cycles overhead per job.
  - Mult-only mode: 1 result per 3 cycles minimum.
- op_ready is 0 in every state except RUN. job_ready is 0 in every state except IDLE.
- A new job is not accepted in the same cycle a result retires; IDLE is always visited for at least one cycle.
- No arithmetic in this block; result width and overflow behaviour are those of mac_block.

Optional Feature:
- Macro: MAC_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles[31:0], counting cycles with state!=IDLE, wrapping at 2^32.
  - Adds output perf_stall[31:0], counting RUN cycles with op_valid=0 plus OUT cycles with res_ready=0.
  - Both counters cleared by rst only.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Accumulate job, single mode, len=4, init=10, A=1,2,3,4, B=2, op_valid held high -> one result, res_data=30, exactly 4 mac_en pulses, res_valid 7 cycles after job accept.
- Mult-only job, single mode, len=2, A=3,5, B=7 -> two results, 21 then 35; op_ready low between beats.
- len=0, acc=1, init=0x55 -> res_data=0x55 with no op handshake; same with acc=0 -> res_data=0.
- Accumulate job len=3 with op_valid gaps of 2 cycles between beats -> mac_en high only on accepted beats, result unchanged vs gapless run.
- res_ready low for 5 cycles in OUT -> res_data stable, job_ready=0, op_ready=0 throughout; single result retired on the first res_ready.
- Assert rst low during RUN after 2 of 4 beats -> all outputs at reset values immediately. After release, a new len=1 job with A=2, B=3, init=0, acc=1 returns 6.
